// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO pair. Signed operands are
// reduced to magnitudes, processed one bit per cycle, then re-signed in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_done;
  logic               r_dz;

  logic               w_accept;
  logic               w_is_md;
  logic               w_is_mt;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_dshift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_ddiff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = start & ~cancel & (r_state == S_IDLE);
  assign w_is_md  = ~op[2];
  assign w_is_mt  = op[2] & ~op[1];
  // op[0]==0 selects the signed variants of both mult and div
  assign w_a_neg  = ~op[0] & din1[WIDTH-1];
  assign w_b_neg  = ~op[0] & din2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -din1 : din1;
  assign w_b_mag  = w_b_neg ? -din2 : din2;

  // Shift-add step: add multiplicand into the upper half, shift the whole product right
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring step: dividend bits stream out of r_acc's low half, quotient bits stream in
  assign w_dshift = {r_rem, r_acc[WIDTH-1]};
  assign w_ge     = w_dshift >= {1'b0, r_b};
  assign w_ddiff  = w_dshift[WIDTH-1:0] - r_b;

  assign w_prod = r_neg_lo ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_md) w_state_next = S_CALC;
      S_CALC: begin
        if (cancel)               w_state_next = S_IDLE;
        else if (r_count == '0)   w_state_next = S_FIX;
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_md) begin
            r_is_div <= op[1];
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_b      <= op[1] ? w_b_mag : w_a_mag;
            r_rem    <= '0;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_count  <= CNT_W'(WIDTH - 1);
            r_dz     <= 1'b0;
          end else if (w_accept && w_is_mt) begin
            if (op[0]) r_lo <= din1;
            else       r_hi <= din1;
            r_done <= 1'b1;
            r_dz   <= 1'b0;
          end
        end
        S_CALC: begin
          if (!cancel) begin
            r_count <= r_count - CNT_W'(1);
            if (r_is_div) begin
              r_rem <= w_ge ? w_ddiff : w_dshift[WIDTH-1:0];
              r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_mul_next;
            end
          end
        end
        S_FIX: begin
          if (!cancel) begin
            if (r_is_div) begin
              // Zero divisor yields an all-ones quotient; the re-signed remainder is din1 itself
              r_lo <= (r_b == '0) ? '1 : (r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
              r_hi <= r_neg_hi ? -r_rem : r_rem;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
            r_done <= 1'b1;
            r_dz   <= r_is_div & (r_b == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign divZero = r_dz;
  assign hi      = r_hi;
  assign lo      = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8, compared
// against plain integer arithmetic and a bench-held HI/LO model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s32_start, s32_cancel, s8_start, s8_cancel;
  logic [2:0]  s32_op, s8_op;
  logic [31:0] s32_din1, s32_din2;
  logic [7:0]  s8_din1, s8_din2;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  logic        sel8;
  logic        obs_busy, obs_done, obs_dz;
  logic [63:0] obs_hi, obs_lo;
  logic [63:0] m_hi [2];
  logic [63:0] m_lo [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32_start), .op(s32_op), .din1(s32_din1),
    .din2(s32_din2), .cancel(s32_cancel), .busy(busy32), .done(done32),
    .divZero(dz32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .op(s8_op), .din1(s8_din1),
    .din2(s8_din2), .cancel(s8_cancel), .busy(busy8), .done(done8),
    .divZero(dz8), .hi(hi8), .lo(lo8));

  assign obs_busy = sel8 ? busy8 : busy32;
  assign obs_done = sel8 ? done8 : done32;
  assign obs_dz   = sel8 ? dz8   : dz32;
  assign obs_hi   = sel8 ? {56'd0, hi8} : {32'd0, hi32};
  assign obs_lo   = sel8 ? {56'd0, lo8} : {32'd0, lo32};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic cn);
    if (sel8) begin
      s8_start = st; s8_op = o; s8_din1 = a[7:0]; s8_din2 = b[7:0]; s8_cancel = cn;
    end else begin
      s32_start = st; s32_op = o; s32_din1 = a[31:0]; s32_din2 = b[31:0]; s32_cancel = cn;
    end
  endtask

  // Reference: integer multiply/divide on sign-extended values, masked to width
  task automatic model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input int w, output logic [63:0] eh, output logic [63:0] el);
    logic [63:0] mask, p;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(b);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'd0; eh = 64'd0; el = 64'd0;
    if (o[1] && b == 64'd0) begin
      eh = a; el = mask;
    end else begin
      case (o)
        3'b000: p = 64'(sa * sb);
        3'b001: p = a * b;
        3'b010: begin eh = 64'(sa % sb) & mask; el = 64'(sa / sb) & mask; end
        3'b011: begin eh = (a % b) & mask; el = (a / b) & mask; end
        default: ;
      endcase
      if (!o[1]) begin
        eh = (p >> w) & mask;
        el = p & mask;
      end
    end
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    int k;
    mask = (64'd1 << w) - 64'd1;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask;
      3:       return 64'd1 << (w - 1);
      4:       return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [63:0] a_in, input logic [63:0] b_in);
    int          w, idx, cnt;
    logic [63:0] mask, a, b, eh, el;
    logic        changed, early, exp_dz;
    w = sel8 ? 8 : 32;
    idx = sel8 ? 1 : 0;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    eh = m_hi[idx];
    el = m_lo[idx];
    if (!o[2])              model(o, a, b, w, eh, el);
    else if (o == 3'b100)   eh = a;
    else if (o == 3'b101)   el = a;
    @(negedge clk);
    set_in(1'b1, o, a, b, 1'b0);
    @(posedge clk);
    #1;
    set_in(1'b0, ~o, ~a, ~b, 1'b0);
    if (!o[2]) begin
      cnt = 0; changed = 1'b0; early = 1'b0;
      exp_dz = o[1] && (b == 64'd0);
      while (cnt < 200) begin
        @(negedge clk);
        if (!obs_busy) break;
        cnt++;
        if (obs_hi != m_hi[idx] || obs_lo != m_lo[idx]) changed = 1'b1;
        if (obs_done) early = 1'b1;
        if (cnt == 3) set_in(1'b1, 3'b100, ~a, b, 1'b0);
        if (cnt == 4) set_in(1'b0, o, a, b, 1'b0);
      end
      chk("busy_cycles", 64'(cnt), 64'(w + 1));
      chk("hilo_hold", 64'(changed), 64'd0);
      chk("done_early", 64'(early), 64'd0);
      chk("done", 64'(obs_done), 64'd1);
      chk("hi", obs_hi, eh);
      chk("lo", obs_lo, el);
      chk("divzero", 64'(obs_dz), 64'(exp_dz));
      @(negedge clk);
      chk("done_pulse", 64'(obs_done), 64'd0);
      chk("divzero_held", 64'(obs_dz), 64'(exp_dz));
    end else begin
      @(negedge clk);
      chk("mt_busy", 64'(obs_busy), 64'd0);
      chk("mt_done", 64'(obs_done), 64'(o == 3'b100 || o == 3'b101));
      chk("mt_hi", obs_hi, eh);
      chk("mt_lo", obs_lo, el);
      @(negedge clk);
      chk("mt_done_pulse", 64'(obs_done), 64'd0);
    end
    m_hi[idx] = eh;
    m_lo[idx] = el;
    $display("OP w=%0d op=%0d a=%h b=%h -> hi=%h lo=%h", w, o, a, b, eh, el);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy32"}, 64'(busy32), 64'd0);
    chk({tag, "_done32"}, 64'(done32), 64'd0);
    chk({tag, "_dz32"},   64'(dz32),   64'd0);
    chk({tag, "_hi32"},   64'(hi32),   64'd0);
    chk({tag, "_lo32"},   64'(lo32),   64'd0);
    chk({tag, "_busy8"},  64'(busy8),  64'd0);
    chk({tag, "_hi8"},    64'(hi8),    64'd0);
    chk({tag, "_lo8"},    64'(lo8),    64'd0);
  endtask

  task automatic cancel_tests();
    logic quiet;
    sel8 = 1'b0;
    // cancel mid-multiply; a stray mthi while busy must be ignored
    @(negedge clk); set_in(1'b1, 3'b000, 64'd123, 64'd456, 1'b0);
    @(posedge clk); #1; set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5)  set_in(1'b1, 3'b100, 64'hDEAD, 64'd0, 1'b0);
      if (i == 6)  set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
      if (i == 10) set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b1);
    end
    @(negedge clk);
    chk("cancel_busy", 64'(obs_busy), 64'd0);
    chk("cancel_done", 64'(obs_done), 64'd0);
    set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    quiet = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (obs_done || obs_busy) quiet = 1'b1;
    end
    chk("cancel_quiet", 64'(quiet), 64'd0);
    chk("cancel_hi", obs_hi, m_hi[0]);
    chk("cancel_lo", obs_lo, m_lo[0]);
    $display("OP cancel mid-mult");
    // cancel on the same edge that would have written the result
    @(negedge clk); set_in(1'b1, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0);
    @(posedge clk); #1; set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    for (int i = 1; i <= 33; i++) @(negedge clk);
    chk("fix_busy", 64'(obs_busy), 64'd1);
    set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    chk("fixcancel_busy", 64'(obs_busy), 64'd0);
    chk("fixcancel_done", 64'(obs_done), 64'd0);
    chk("fixcancel_hi", obs_hi, m_hi[0]);
    chk("fixcancel_lo", obs_lo, m_lo[0]);
    $display("OP cancel at FIX");
    // cancel while idle blocks a start on the same edge
    set_in(1'b1, 3'b101, ~m_lo[0], 64'd0, 1'b1);
    @(negedge clk);
    chk("idlecancel_done", 64'(obs_done), 64'd0);
    chk("idlecancel_lo", obs_lo, m_lo[0]);
    set_in(1'b1, 3'b000, 64'd5, 64'd5, 1'b1);
    @(negedge clk);
    chk("idlecancel_busy", 64'(obs_busy), 64'd0);
    set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    $display("OP cancel in idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int r;
    logic [2:0] o;
    sel8 = 1'b0;
    s32_start = 0; s32_cancel = 0; s32_op = 0; s32_din1 = 0; s32_din2 = 0;
    s8_start = 0;  s8_cancel = 0;  s8_op = 0;  s8_din1 = 0;  s8_din2 = 0;
    for (int i = 0; i < 2; i++) begin m_hi[i] = 64'd0; m_lo[i] = 64'd0; end
    rst_n = 1'b0;
    #12;
    check_reset("rst");
    @(negedge clk); rst_n = 1'b1;

    run_op(3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF);
    chk("multu_k_hi", obs_hi, 64'hFFFFFFFE); chk("multu_k_lo", obs_lo, 64'h1);
    run_op(3'b000, 64'hFFFFFFF9, 64'd3);
    chk("mult_k_hi", obs_hi, 64'hFFFFFFFF); chk("mult_k_lo", obs_lo, 64'hFFFFFFEB);
    run_op(3'b010, 64'hFFFFFFF9, 64'd2);
    chk("div_k_hi", obs_hi, 64'hFFFFFFFF); chk("div_k_lo", obs_lo, 64'hFFFFFFFD);
    run_op(3'b011, 64'd7, 64'd2);
    chk("divu_k_hi", obs_hi, 64'd1); chk("divu_k_lo", obs_lo, 64'd3);
    run_op(3'b010, 64'h80000000, 64'hFFFFFFFF);
    chk("divmin_k_hi", obs_hi, 64'd0); chk("divmin_k_lo", obs_lo, 64'h80000000);
    run_op(3'b011, 64'd5, 64'd0);
    chk("divz_k_hi", obs_hi, 64'd5); chk("divz_k_lo", obs_lo, 64'hFFFFFFFF);
    chk("divz_k_flag", 64'(obs_dz), 64'd1);
    run_op(3'b010, 64'hFFFFFFF9, 64'd0);
    run_op(3'b010, 64'd9, 64'd2);

    // mthi / mtlo back to back
    @(negedge clk); set_in(1'b1, 3'b100, 64'h1234, 64'd0, 1'b0);
    @(negedge clk);
    chk("mthi_busy", 64'(obs_busy), 64'd0); chk("mthi_done", 64'(obs_done), 64'd1);
    chk("mthi_hi", obs_hi, 64'h1234);
    set_in(1'b1, 3'b101, 64'h5678, 64'd0, 1'b0);
    @(negedge clk);
    chk("mtlo_busy", 64'(obs_busy), 64'd0); chk("mtlo_done", 64'(obs_done), 64'd1);
    chk("mtlo_hi", obs_hi, 64'h1234); chk("mtlo_lo", obs_lo, 64'h5678);
    set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("mtlo_done_pulse", 64'(obs_done), 64'd0);
    m_hi[0] = 64'h1234; m_lo[0] = 64'h5678;
    $display("OP mthi 1234 / mtlo 5678 back to back");

    cancel_tests();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      o = (r < 8) ? 3'(r % 4) : 3'(r - 4);
      run_op(o, pick(32), pick(32));
    end

    sel8 = 1'b1;
    run_op(3'b001, 64'hFF, 64'hFF);
    chk("w8_k_hi", obs_hi, 64'hFE); chk("w8_k_lo", obs_lo, 64'h01);
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 11);
      o = (r < 8) ? 3'(r % 4) : 3'(r - 4);
      run_op(o, pick(8), pick(8));
    end
    run_op(3'b100, 64'hA5, 64'd0);

    // asynchronous reset in the middle of a divide
    sel8 = 1'b0;
    run_op(3'b100, 64'hCAFE0001, 64'd0);
    @(negedge clk); set_in(1'b1, 3'b010, 64'd100, 64'd7, 1'b0);
    @(posedge clk); #1; set_in(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("prerst_busy", 64'(busy32), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    for (int i = 0; i < 2; i++) begin m_hi[i] = 64'd0; m_lo[i] = 64'd0; end
    @(negedge clk); rst_n = 1'b1;
    $display("OP async reset mid-div");
    run_op(3'b011, 64'd100, 64'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
